// File: rtl/flu_pkg.sv
// Shared types and defaults for the feedback logic unit.
// Output-register state encoding and default WIDTH/CNT_W values.
package flu_pkg;

    localparam int FLU_WIDTH_DEF = 8;
    localparam int FLU_CNT_W_DEF = 16;

    typedef enum logic {
        FLU_EMPTY = 1'b0,
        FLU_FULL  = 1'b1
    } flu_state_t;

endpackage

// File: rtl/flu_lane.sv
// One bit of the feedback function: XOR when the lane's previous
// result was 0, AND when it was 1. Ports: prev, a, b -> res.
module flu_lane
    import flu_pkg::*;
(
    input  logic prev,
    input  logic a,
    input  logic b,
    output logic res
);

    assign res = prev ? (a & b) : (a ^ b);

endmodule

// File: rtl/feedback_logic_unit.sv
// Per-bit XOR/AND feedback combiner with valid/ready handshakes,
// a one-entry output register, per-lane history, sync clear and an
// accept counter. Ports: clk, rst_n, clear, in_valid/in_ready/in_a/
// in_b, out_valid/out_ready/out_c, acc_cnt. Defining FLU_PARITY_EN
// adds out_parity (^ of the registered result).
module feedback_logic_unit
    import flu_pkg::*;
#(
    parameter int WIDTH = FLU_WIDTH_DEF,
    parameter int CNT_W = FLU_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c,
    output logic [CNT_W-1:0] acc_cnt
`ifdef FLU_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    flu_state_t       state;
    flu_state_t       state_nxt;
    logic [WIDTH-1:0] hist;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] res;
    logic             accept;

    // Clear wins over stored history, even on an accepting cycle.
    assign prev      = clear ? '0 : hist;
    assign out_valid = (state == FLU_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        flu_lane u_lane (
            .prev (prev[i]),
            .a    (in_a[i]),
            .b    (in_b[i]),
            .res  (res[i])
        );
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FLU_EMPTY: begin
                if (accept)
                    state_nxt = FLU_FULL;
            end
            FLU_FULL: begin
                if (out_ready && !accept)
                    state_nxt = FLU_EMPTY;
            end
            default: state_nxt = FLU_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= FLU_EMPTY;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist    <= '0;
            out_c   <= '0;
            acc_cnt <= '0;
        end else if (accept) begin
            hist    <= res;
            out_c   <= res;
            acc_cnt <= acc_cnt + 1'b1;
        end else if (clear) begin
            hist    <= '0;
        end
    end

`ifdef FLU_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_parity <= 1'b0;
        else if (accept)
            out_parity <= ^res;
    end
`endif

endmodule

// File: tb/tb_feedback_logic_unit.sv
// Self-checking bench for feedback_logic_unit (WIDTH=4, CNT_W=2):
// directed steps followed by random traffic against a reference model.
module tb_feedback_logic_unit;

    localparam int W  = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_c;
    logic [CW-1:0] acc_cnt;
`ifdef FLU_PARITY_EN
    logic          out_parity;
`endif

    int errors = 0;
    int checks = 0;

    logic [W-1:0]  m_hist;
    logic [W-1:0]  m_oc;
    logic          m_ov;
    int            m_cnt;

    feedback_logic_unit #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .acc_cnt   (acc_cnt)
`ifdef FLU_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_res(input logic [W-1:0] p,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++)
            r[i] = p[i] ? (a[i] & b[i]) : (a[i] ^ b[i]);
        return r;
    endfunction

    task automatic model_reset();
        m_hist = '0;
        m_oc   = '0;
        m_ov   = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        chk({tag, ".out_c"}, 32'(out_c), 32'(m_oc));
        chk({tag, ".acc_cnt"}, 32'(acc_cnt), 32'(m_cnt % (1 << CW)));
`ifdef FLU_PARITY_EN
        chk({tag, ".parity"}, 32'(out_parity), 32'(^m_oc));
`endif
    endtask

    // Called just after a rising edge: drive, check ready, clock once.
    task automatic step(input string tag, input logic v, input logic r,
                        input logic c, input logic [W-1:0] a,
                        input logic [W-1:0] b);
        logic         rdy;
        logic [W-1:0] p;
        in_valid  = v;
        out_ready = r;
        clear     = c;
        in_a      = a;
        in_b      = b;
        #1;
        rdy = !m_ov || r;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        p = c ? '0 : m_hist;
        if (v && rdy) begin
            m_hist = model_res(p, a, b);
            m_oc   = m_hist;
            m_ov   = 1'b1;
            m_cnt++;
        end else begin
            if (c)
                m_hist = '0;
            if (r)
                m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outs(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset");
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        step("first", 1, 1, 0, 4'b1100, 4'b1010);
        chk("first.val", 32'(out_c), 32'b0110);
        step("mixed", 1, 1, 0, 4'b1111, 4'b0101);
        chk("mixed.val", 32'(out_c), 32'b1100);

        for (int k = 0; k < 3; k++) begin
            step("bp", 1, 0, 0, 4'(k), 4'(k + 5));
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            chk("bp.hold", 32'(out_c), 32'b1100);
        end

        step("clracc", 1, 1, 1, 4'b1111, 4'b0101);
        chk("clracc.val", 32'(out_c), 32'b1010);
        chk("clracc.cnt", 32'(acc_cnt), 32'd3);

        step("wrap0", 1, 1, 0, 4'b0011, 4'b0110);
        chk("wrap.cnt", 32'(acc_cnt), 32'd0);
        for (int k = 0; k < 3; k++)
            step("b2b", 1, 1, 0, 4'(k * 3), 4'(k + 9));

        // Async reset while FULL.
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs("async_rst");
        chk("async_rst.in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        step("post_rst", 1, 1, 0, 4'b1111, 4'b0101);
        chk("post_rst.val", 32'(out_c), 32'b1010);

        for (int k = 0; k < 300; k++)
            step("rand", 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 7) == 0),
                 4'($urandom), 4'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/feedback_logic_unit.md
# feedback_logic_unit

- Clocked, parametrised successor to the team's single-bit XOR/AND feedback cell.
- Combines two WIDTH-bit operands per bit. Each bit uses XOR when its previous result bit was 0 and AND when it was 1.
- Operands enter and results leave through valid/ready handshakes, with a one-entry output register.
- Sits between an operand producer and a result consumer. It keeps per-lane history, a synchronous clear and a transfer counter.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- CNT_W, 16, width of accepted-transfer counter (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- clear  input  1  synchronous history clear
- in_valid  input  1  operand pair valid
- in_ready  output  1  unit can accept an operand pair
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- out_valid  output  1  out_c holds an unconsumed result
- out_ready  input  1  consumer accepts result
- out_c  output  WIDTH  result
- acc_cnt  output  CNT_W  number of accepted operand pairs, modulo 2^CNT_W

## Operation
- History register hist (WIDTH bits) holds the last computed result.
- prev = clear ? 0 : hist. Clear takes priority: a clear in the same cycle as an accept computes against zero history.
- Per bit i: res[i] = prev[i] ? (in_a[i] & in_b[i]) : (in_a[i] ^ in_b[i]).
- Accept = in_valid && in_ready. On accept:
  - hist <= res, out_c <= res, out_valid <= 1.
  - acc_cnt <= acc_cnt + 1, wrapping from 2^CNT_W−1 to 0.
- Clear without accept: hist <= 0. out_c, out_valid and acc_cnt are unchanged; a pending result is still delivered.
- Output FSM has two states:
  - EMPTY (out_valid=0) → FULL on accept.
  - FULL → EMPTY on out_ready with no accept.
  - FULL stays FULL on out_ready together with an accept; the register is overwritten with the new result.
  - FULL stays FULL on !out_ready; out_c is held stable.
- in_ready = !out_valid || out_ready. This path is combinational; there are no bubbles at full throughput.
- in_a/in_b are ignored when in_valid=0 or in_ready=0.

## Timing
- Reset values: hist=0, out_c=0, out_valid=0, acc_cnt=0, so in_ready=1. With FLU_PARITY_EN, out_parity=0.
- Latency: result is visible on out_c/out_valid on the cycle after accept.
- Throughput: one accept per cycle while out_ready=1.
- Reset asserted mid-operation clears all state immediately, asynchronously. Any pending result is lost.
- Reset deassertion is synchronised externally; the first accept is legal on the first clock edge with rst_n=1.

## Configuration
- FLU_PARITY_EN defined:
  - Adds output port out_parity (1 bit), equal to ^res.
  - Registered alongside out_c under the same handshake and held with it.
- FLU_PARITY_EN undefined: the port and its register are absent. All other behaviour is identical.

## Structure
- flu_pkg:
  - Output state typedef {FLU_EMPTY, FLU_FULL}.
  - Default WIDTH/CNT_W localparams.
- Sub-module flu_lane: one bit's combinational res from prev, a and b. It is instantiated WIDTH times via generate. The top holds all registers.

## Test plan
Bench uses WIDTH=4, CNT_W=2.
- Reset: hold rst_n=0 → out_valid=0, out_c=4'b0000, acc_cnt=0, in_ready=1.
- First accept, from reset, out_ready=1: a=1100, b=1010 → next cycle out_c=0110, out_valid=1, acc_cnt=1.
- Mixed-history accept, following the previous result: a=1111, b=0101 → out_c=1100 (bits 1,2 AND; bits 0,3 XOR).
- Backpressure: out_ready=0 with FULL, in_valid=1 for 3 cycles → in_ready=0, out_c stable, acc_cnt unchanged, hist unchanged.
- Clear with accept: hist=1100, clear=1, a=1111, b=0101 → out_c=1010.
- Counter wrap and reset:
  - 4 back-to-back accepts → acc_cnt wraps to 0.
  - rst_n pulsed low while FULL → out_valid=0 and hist=0 at once; next accept uses XOR on all bits.
